// File: rtl/sm3_pkg.sv
// Shared SM3 constants, state encoding and XOR/rotate helpers.
package sm3_pkg;

    localparam logic [31:0] SM3_T_LO = 32'h79CC4519;
    localparam logic [31:0] SM3_T_HI = 32'h7A879D8A;

    localparam logic [3:0]  SM3_LAST_LOAD  = 4'd15;
    localparam logic [5:0]  SM3_LAST_ROUND = 6'd63;

    typedef enum logic {
        LOAD,
        RUN
    } sm3_state_e;

    // Upper half of the doubled word is the rotate; n=0 falls out naturally.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    function automatic logic [31:0] sm3_tj(input logic [5:0] j);
        logic [31:0] base;
        base = (j < 6'd16) ? SM3_T_LO : SM3_T_HI;
        return rotl(base, j[4:0]);
    endfunction

endpackage

// File: rtl/sm3_msg_expnd_if.sv
// Block-input and round-output handshake bundle of the message expander.
interface sm3_msg_expnd_if;

    logic        clr_i;
    logic [31:0] data_i;
    logic        data_vld_i;
    logic        data_rdy_o;
    logic        exp_vld_o;
    logic        exp_rdy_i;
    logic [5:0]  round_o;
    logic [31:0] wj_o;
    logic [31:0] wjj_o;
    logic [31:0] tj_o;
    logic        cmprss_round_sm_16_o;
    logic        blk_done_o;

    modport slave (
        input  clr_i, data_i, data_vld_i, exp_rdy_i,
        output data_rdy_o, exp_vld_o, round_o, wj_o, wjj_o, tj_o,
               cmprss_round_sm_16_o, blk_done_o
    );

    modport master (
        output clr_i, data_i, data_vld_i, exp_rdy_i,
        input  data_rdy_o, exp_vld_o, round_o, wj_o, wjj_o, tj_o,
               cmprss_round_sm_16_o, blk_done_o
    );

endinterface

// File: rtl/sm3_wgen.sv
// Combinational SM3 next-word generator: W_{j+16} from the window taps.
module sm3_wgen
    import sm3_pkg::*;
(
    input  logic [31:0] i_w0,
    input  logic [31:0] i_w3,
    input  logic [31:0] i_w7,
    input  logic [31:0] i_w10,
    input  logic [31:0] i_w13,
    output logic [31:0] o_wnext
);

    logic [31:0] w_p1_in;

    assign w_p1_in = i_w0 ^ i_w7 ^ rotl(i_w13, 5'd15);
    assign o_wnext = p1(w_p1_in) ^ rotl(i_w3, 5'd7) ^ i_w10;

endmodule

// File: rtl/sm3_msg_expnd.sv
// SM3 message expansion: loads 16 words, then streams W_j, W'_j, T_j per round.
module sm3_msg_expnd
    import sm3_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    sm3_msg_expnd_if.slave s_if
);

    sm3_state_e  r_state;
    sm3_state_e  w_state_nxt;
    logic [5:0]  r_round;
    logic [5:0]  w_round_nxt;
    logic [3:0]  r_ld_cnt;
    logic [3:0]  w_ld_cnt_nxt;
    logic        r_blk_done;
    logic        w_blk_done_nxt;
    logic [31:0] r_win [16];

    logic        w_shift;
    logic [31:0] w_shift_in;
    logic [31:0] w_wnext;
    logic        w_data_hs;
    logic        w_exp_hs;

    sm3_wgen u_wgen (
        .i_w0    (r_win[0]),
        .i_w3    (r_win[3]),
        .i_w7    (r_win[7]),
        .i_w10   (r_win[10]),
        .i_w13   (r_win[13]),
        .o_wnext (w_wnext)
    );

    assign w_data_hs = (r_state == LOAD) && s_if.data_vld_i;
    assign w_exp_hs  = (r_state == RUN)  && s_if.exp_rdy_i;

    // Abort outranks both handshakes, so neither shift nor count happens under clr_i.
    always_comb begin
        w_state_nxt    = r_state;
        w_round_nxt    = r_round;
        w_ld_cnt_nxt   = r_ld_cnt;
        w_blk_done_nxt = 1'b0;
        w_shift        = 1'b0;
        w_shift_in     = s_if.data_i;
        if (s_if.clr_i) begin
            w_state_nxt  = LOAD;
            w_round_nxt  = '0;
            w_ld_cnt_nxt = '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_data_hs) begin
                        w_shift      = 1'b1;
                        w_ld_cnt_nxt = r_ld_cnt + 4'd1;
                        if (r_ld_cnt == SM3_LAST_LOAD) begin
                            w_state_nxt  = RUN;
                            w_round_nxt  = '0;
                            w_ld_cnt_nxt = '0;
                        end
                    end
                end
                RUN: begin
                    if (w_exp_hs) begin
                        w_shift     = 1'b1;
                        w_shift_in  = w_wnext;
                        w_round_nxt = r_round + 6'd1;
                        if (r_round == SM3_LAST_ROUND) begin
                            w_state_nxt    = LOAD;
                            w_round_nxt    = '0;
                            w_ld_cnt_nxt   = '0;
                            w_blk_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = LOAD;
                    w_round_nxt  = '0;
                    w_ld_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_round    <= '0;
            r_ld_cnt   <= '0;
            r_blk_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_round    <= w_round_nxt;
            r_ld_cnt   <= w_ld_cnt_nxt;
            r_blk_done <= w_blk_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_shift) begin
            for (int unsigned i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_shift_in;
        end
    end

    assign s_if.data_rdy_o           = (r_state == LOAD);
    assign s_if.exp_vld_o            = (r_state == RUN);
    assign s_if.round_o              = r_round;
    assign s_if.wj_o                 = r_win[0];
    assign s_if.wjj_o                = r_win[0] ^ r_win[4];
    assign s_if.tj_o                 = sm3_tj(r_round);
    assign s_if.cmprss_round_sm_16_o = (r_round < 6'd16);
    assign s_if.blk_done_o           = r_blk_done;

endmodule

// File: tb/tb_sm3_msg_expnd.sv
// Directed self-checking bench for sm3_msg_expnd using the padded "abc" block.
module tb_sm3_msg_expnd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm3_msg_expnd_if bus ();

    sm3_msg_expnd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int load_cyc = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] blk [16];
    logic [31:0] wm  [68];
    logic [31:0] hand_w [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] p1m(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    function automatic logic [31:0] tref(input int j);
        return rl((j < 16) ? 32'h79CC4519 : 32'h7A879D8A, j);
    endfunction

    task automatic build_model();
        for (int i = 0; i < 16; i++) wm[i] = blk[i];
        for (int j = 16; j < 68; j++)
            wm[j] = p1m(wm[j-16] ^ wm[j-9] ^ rl(wm[j-3], 15)) ^ rl(wm[j-13], 7) ^ wm[j-6];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
        build_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_data_rdy"}, bus.data_rdy_o, 1'b1);
        chk1({tag, "_exp_vld"},  bus.exp_vld_o, 1'b0);
        chk ({tag, "_round"},    32'(bus.round_o), 32'd0);
        chk ({tag, "_wj"},       bus.wj_o, 32'h0);
        chk ({tag, "_wjj"},      bus.wjj_o, 32'h0);
        chk ({tag, "_tj"},       bus.tj_o, 32'h79CC4519);
        chk1({tag, "_sm16"},     bus.cmprss_round_sm_16_o, 1'b1);
        chk1({tag, "_blk_done"}, bus.blk_done_o, 1'b0);
    endtask

    // Presents n words from blk[], optionally with idle gaps between them.
    task automatic load_words(input int n, input bit gaps);
        int ng;
        for (int i = 0; i < n; i++) begin
            ng = gaps ? $urandom_range(0, 3) : 0;
            for (int g = 0; g < ng; g++) begin
                bus.data_vld_i = 1'b0;
                tick();
                chk1("gap_exp_vld", bus.exp_vld_o, 1'b0);
                chk1("gap_data_rdy", bus.data_rdy_o, 1'b1);
            end
            chk1("load_exp_vld", bus.exp_vld_o, 1'b0);
            chk1("load_data_rdy", bus.data_rdy_o, 1'b1);
            bus.data_vld_i = 1'b1;
            bus.data_i     = blk[i];
            load_cyc       = cyc;
            tick();
        end
        bus.data_vld_i = 1'b0;
    endtask

    // Runs rounds against the model; returns early when round stop_at is showing.
    task automatic run_block(input bit stall, input bit hand, input int stop_at);
        int j = 0;
        int budget = 0;
        bit stalled = 1'b0;
        logic rdy;
        logic [5:0]  s_round;
        logic [31:0] s_wj, s_wjj, s_tj;
        while (j < 64 && budget < 1000) begin
            if (stalled) begin
                chk("stall_round", 32'(bus.round_o), 32'(s_round));
                chk("stall_wj", bus.wj_o, s_wj);
                chk("stall_wjj", bus.wjj_o, s_wjj);
                chk("stall_tj", bus.tj_o, s_tj);
            end
            chk1("run_exp_vld", bus.exp_vld_o, 1'b1);
            chk1("run_data_rdy", bus.data_rdy_o, 1'b0);
            chk1("run_blk_done", bus.blk_done_o, 1'b0);
            chk("run_round", 32'(bus.round_o), 32'(j));
            if (j == stop_at) return;
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy) begin
                chk("wj", bus.wj_o, wm[j]);
                chk("wjj", bus.wjj_o, wm[j] ^ wm[j+4]);
                chk("tj", bus.tj_o, tref(j));
                chk1("sm16", bus.cmprss_round_sm_16_o, j < 16);
                if (hand) begin
                    if (j == 0) begin
                        chk("hand_wj0", bus.wj_o, 32'h61626380);
                        chk("hand_wjj0", bus.wjj_o, 32'h61626380);
                        chk("hand_tj0", bus.tj_o, 32'h79CC4519);
                        chk1("hand_sm16_0", bus.cmprss_round_sm_16_o, 1'b1);
                    end
                    if (j == 1) chk("hand_tj1", bus.tj_o, 32'hF3988A32);
                    if (j == 16) begin
                        chk("hand_tj16", bus.tj_o, 32'h9D8A7A87);
                        chk1("hand_sm16_16", bus.cmprss_round_sm_16_o, 1'b0);
                    end
                    if (j >= 16 && j < 20) chk("hand_wj", bus.wj_o, hand_w[j-16]);
                end
                j++;
            end
            bus.exp_rdy_i = rdy;
            stalled = !rdy;
            s_round = bus.round_o;
            s_wj    = bus.wj_o;
            s_wjj   = bus.wjj_o;
            s_tj    = bus.tj_o;
            tick();
            budget++;
        end
        bus.exp_rdy_i = 1'b0;
        chk("run_rounds_done", 32'(j), 32'd64);
        chk1("done_pulse", bus.blk_done_o, 1'b1);
        chk1("done_data_rdy", bus.data_rdy_o, 1'b1);
        chk1("done_exp_vld", bus.exp_vld_o, 1'b0);
        chk("done_round", 32'(bus.round_o), 32'd0);
        done_cyc = cyc;
        tick();
        chk1("done_pulse_end", bus.blk_done_o, 1'b0);
    endtask

    initial begin
        hand_w[0] = 32'h9092E200;
        hand_w[1] = 32'h00000000;
        hand_w[2] = 32'h000C0606;
        hand_w[3] = 32'h719C70ED;
        bus.clr_i      = 1'b0;
        bus.data_i     = '0;
        bus.data_vld_i = 1'b0;
        bus.exp_rdy_i  = 1'b0;

        #2;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset("post_reset");

        // abc block, no backpressure, directed values and latency
        set_abc();
        load_words(16, 1'b0);
        run_block(1'b0, 1'b1, -1);
        chk("blk_latency", 32'(done_cyc - load_cyc), 32'd65);

        // abc block with load gaps and consumer stalls
        load_words(16, 1'b1);
        run_block(1'b1, 1'b1, -1);

        // random block with gaps and stalls
        set_rand();
        load_words(16, 1'b1);
        run_block(1'b1, 1'b0, -1);

        // abort at round 37 with a simultaneous round handshake
        set_abc();
        load_words(16, 1'b0);
        run_block(1'b0, 1'b0, 37);
        bus.clr_i     = 1'b1;
        bus.exp_rdy_i = 1'b1;
        tick();
        bus.clr_i     = 1'b0;
        bus.exp_rdy_i = 1'b0;
        chk1("clr_data_rdy", bus.data_rdy_o, 1'b1);
        chk1("clr_exp_vld", bus.exp_vld_o, 1'b0);
        chk("clr_round", 32'(bus.round_o), 32'd0);
        chk1("clr_blk_done", bus.blk_done_o, 1'b0);
        tick();
        chk1("clr_blk_done2", bus.blk_done_o, 1'b0);

        // partial load, abort (with a word offered), then a full block
        set_rand();
        load_words(5, 1'b0);
        bus.clr_i      = 1'b1;
        bus.data_vld_i = 1'b1;
        tick();
        bus.clr_i      = 1'b0;
        bus.data_vld_i = 1'b0;
        chk1("clr_load_exp_vld", bus.exp_vld_o, 1'b0);
        set_abc();
        load_words(16, 1'b0);
        run_block(1'b0, 1'b1, -1);

        // asynchronous reset mid-run
        set_rand();
        load_words(16, 1'b0);
        run_block(1'b0, 1'b0, 20);
        bus.exp_rdy_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset("rst_release");
        set_abc();
        load_words(16, 1'b1);
        run_block(1'b1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
